gpu_cmd_scheduler: RTL

- Sequences host GPU commands onto the layer-header/layer-RAM command port.
- Outside a render, commands are issued in arrival order.
- During a render:
  - Reads bypass immediately.
  - Writes are parked in a write queue.
- The queue drains after render_done, and the next render is granted only after the drain completes.
- Sits between the command interface and the layer header/RAM blocks, and owns the render handshake with the frame controller.

---
 rtl/gpu_cmd_pkg.sv | 21 ++
 rtl/gpu_cmd_scheduler_wq.sv | 57 +++++
 rtl/gpu_cmd_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gpu_cmd_pkg.sv
// Shared types and default widths for the GPU command scheduler.
package gpu_cmd_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RENDER,
      RENDER_RD,
      DRAIN
   } state_e;

   // Layout of one parked write at the default widths.
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } wq_entry_t;

endpackage

// File: rtl/gpu_cmd_scheduler_wq.sv
// Synchronous FIFO that parks writes while a render is in progress.
module gpu_write_queue
   import gpu_cmd_pkg::*;
#(
   parameter int unsigned WQ_DEPTH = 16,
   parameter int unsigned WIDTH    = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           din_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(WQ_DEPTH):0]  count_o
);

   localparam int unsigned AW = $clog2(WQ_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [WQ_DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CW'(WQ_DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Storage array; contents are don't-care while the queue is empty.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
         else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
      end
   end

endmodule

// File: rtl/gpu_cmd_scheduler.sv
// Orders host commands onto the layer memory port around render windows.
module gpu_cmd_scheduler
   import gpu_cmd_pkg::*;
#(
   parameter int unsigned WQ_DEPTH = 16,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF
) (
   input  logic                       cmd_clk_in,
   input  logic                       rst_in,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_we,
   input  logic [ADDR_W-1:0]          cmd_addr,
   input  logic [DATA_W-1:0]          cmd_wdata,
   output logic                       rsp_valid,
   output logic [DATA_W-1:0]          rsp_data,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic                       mem_ready,
   input  logic                       mem_rvalid,
   input  logic [DATA_W-1:0]          mem_rdata,
   input  logic                       render_req,
   output logic                       render_grant,
   input  logic                       render_done,
   output logic                       render_active,
   output logic [$clog2(WQ_DEPTH):0]  wq_count
);

   state_e               state_q, state_d;
   logic                 done_flag_q, done_flag_d;
   logic                 mem_req_q, mem_we_q;
   logic [ADDR_W-1:0]    mem_addr_q;
   logic [DATA_W-1:0]    mem_wdata_q;
   logic                 rsp_valid_q;
   logic [DATA_W-1:0]    rsp_data_q;

   logic                 ready, grant, issue, push, pop;
   logic                 wq_full, wq_empty;
   logic [ADDR_W+DATA_W-1:0] wq_dout;

   gpu_write_queue #(
      .WQ_DEPTH (WQ_DEPTH),
      .WIDTH    (ADDR_W + DATA_W)
   ) u_wq (
      .clk_i   (cmd_clk_in),
      .rst_i   (rst_in),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   ({cmd_addr, cmd_wdata}),
      .dout_o  (wq_dout),
      .full_o  (wq_full),
      .empty_o (wq_empty),
      .count_o (wq_count)
   );

   // Ready and grant are combinational on render_req, so mask them while reset holds state.
   assign cmd_ready     = ready && !rst_in;
   assign render_grant  = grant && !rst_in;
   assign render_active = (state_q == RENDER) || (state_q == RENDER_RD);
   assign mem_req       = mem_req_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;

   // Next-state, handshake and queue control.
   always_comb begin
      state_d     = state_q;
      done_flag_d = done_flag_q;
      ready       = 1'b0;
      grant       = 1'b0;
      issue       = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready = !mem_req_q && !render_req;
            if (render_req && !mem_req_q && wq_empty) begin
               grant   = 1'b1;
               state_d = RENDER;
            end else if (cmd_valid && ready) begin
               issue = 1'b1;
               if (!cmd_we) state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (mem_rvalid) state_d = IDLE;
         end
         RENDER: begin
            ready = !mem_req_q && !wq_full;
            if (cmd_valid && ready) begin
               if (cmd_we) begin
                  push = 1'b1;
               end else begin
                  issue   = 1'b1;
                  state_d = RENDER_RD;
               end
            end
            // A done arriving with a read issue is remembered until that read returns.
            if (render_done) begin
               if (state_d == RENDER_RD) done_flag_d = 1'b1;
               else                      state_d     = DRAIN;
            end
         end
         RENDER_RD: begin
            if (render_done) done_flag_d = 1'b1;
            if (mem_rvalid) begin
               state_d     = (done_flag_q || render_done) ? DRAIN : RENDER;
               done_flag_d = 1'b0;
            end
         end
         DRAIN: begin
            if (!mem_req_q) begin
               if (!wq_empty) pop     = 1'b1;
               else           state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and done-flag registers.
   always_ff @(posedge cmd_clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         done_flag_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_flag_q <= done_flag_d;
      end
   end

   // Issue register: loads a command or queue head, holds request until accepted.
   always_ff @(posedge cmd_clk_in or posedge rst_in) begin
      if (rst_in) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else if (issue) begin
         mem_req_q   <= 1'b1;
         mem_we_q    <= cmd_we;
         mem_addr_q  <= cmd_addr;
         mem_wdata_q <= cmd_wdata;
      end else if (pop) begin
         mem_req_q                 <= 1'b1;
         mem_we_q                  <= 1'b1;
         {mem_addr_q, mem_wdata_q} <= wq_dout;
      end else if (mem_req_q && mem_ready) begin
         mem_req_q <= 1'b0;
      end
   end

   // Read response is a registered copy of the memory return.
   always_ff @(posedge cmd_clk_in or posedge rst_in) begin
      if (rst_in) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= mem_rvalid;
         rsp_data_q  <= mem_rdata;
      end
   end

endmodule
